// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction port, data port and the shared memory port.
// Signal names keep the arbiter's point of view (i_ = into arbiter, o_ = out of it).
// slave  : the arbiter side.
// master : the environment side (cores and memory model).
interface mem_arbiter_if;
    logic        i_imem_req;
    logic [31:0] i_imem_addr;
    logic        o_imem_ready;
    logic        o_imem_valid;
    logic [31:0] o_imem_rdata;

    logic        i_dmem_req;
    logic        i_dmem_ren;
    logic        i_dmem_wen;
    logic [31:0] i_dmem_addr;
    logic [31:0] i_dmem_wdata;
    logic [3:0]  i_dmem_mask;
    logic        o_dmem_ready;
    logic        o_dmem_valid;
    logic [31:0] o_dmem_rdata;
    logic        o_dmem_err;

    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_wen;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_imem_req, i_imem_addr,
        output o_imem_ready, o_imem_valid, o_imem_rdata,
        input  i_dmem_req, i_dmem_ren, i_dmem_wen, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
        output o_dmem_ready, o_dmem_valid, o_dmem_rdata, o_dmem_err,
        output o_mem_req, o_mem_addr, o_mem_wdata, o_mem_wen, o_mem_mask,
        input  i_mem_ready, i_mem_valid, i_mem_rdata
    );

    modport master (
        output i_imem_req, i_imem_addr,
        input  o_imem_ready, o_imem_valid, o_imem_rdata,
        output i_dmem_req, i_dmem_ren, i_dmem_wen, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
        input  o_dmem_ready, o_dmem_valid, o_dmem_rdata, o_dmem_err,
        input  o_mem_req, o_mem_addr, o_mem_wdata, o_mem_wen, o_mem_mask,
        output i_mem_ready, i_mem_valid, i_mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between a fetch port and a data port,
// one transaction outstanding at a time.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break IDLE ties in favour of the
// requester not granted last; otherwise the data port always wins ties.
//
// state | meaning
// IDLE  | no transaction; grant a requester combinationally
// ISSUE | drive o_mem_req with latched fields until the memory accepts
// WAIT  | wait for the memory response, forward it to the owner
// ERR   | report a read+write data request as an error, no memory access
module mem_arbiter (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bus,
    output logic          o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR} state_t;

    state_t      state_q, state_d;
    logic        owner_dmem_q, owner_dmem_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        wen_q, wen_d;
    logic        grant_imem, grant_dmem;
    logic        prio_dmem;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic prio_dmem_q, prio_dmem_d;
    assign prio_dmem = prio_dmem_q;

    // Priority flips to the other requester after every grant.
    always_comb begin
        prio_dmem_d = prio_dmem_q;
        if (grant_dmem)      prio_dmem_d = 1'b0;
        else if (grant_imem) prio_dmem_d = 1'b1;
    end

    // Priority pointer register, data port preferred out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) prio_dmem_q <= 1'b1;
        else       prio_dmem_q <= prio_dmem_d;
    end
`else
    assign prio_dmem = 1'b1;
`endif

    // Grant decision, only in IDLE and never while reset is applied.
    always_comb begin
        grant_dmem = 1'b0;
        grant_imem = 1'b0;
        if (state_q == S_IDLE && !i_rst) begin
            grant_dmem = bus.i_dmem_req && (!bus.i_imem_req || prio_dmem);
            grant_imem = bus.i_imem_req && !grant_dmem;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_dmem)
                    state_d = (bus.i_dmem_ren && bus.i_dmem_wen) ? S_ERR : S_ISSUE;
                else if (grant_imem)
                    state_d = S_ISSUE;
            end
            S_ISSUE: if (bus.i_mem_ready) state_d = S_WAIT;
            S_WAIT:  if (bus.i_mem_valid) state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Transaction fields captured at grant; a fetch is a full-word read.
    always_comb begin
        owner_dmem_d = owner_dmem_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        wen_d        = wen_q;
        if (grant_dmem) begin
            owner_dmem_d = 1'b1;
            addr_d       = bus.i_dmem_addr;
            wdata_d      = bus.i_dmem_wdata;
            mask_d       = bus.i_dmem_mask;
            wen_d        = bus.i_dmem_wen;
        end else if (grant_imem) begin
            owner_dmem_d = 1'b0;
            addr_d       = bus.i_imem_addr;
            wdata_d      = 32'h0;
            mask_d       = 4'hF;
            wen_d        = 1'b0;
        end
    end

    // Transaction field registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            owner_dmem_q <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            mask_q       <= 4'h0;
            wen_q        <= 1'b0;
        end else begin
            owner_dmem_q <= owner_dmem_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            wen_q        <= wen_d;
        end
    end

    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_mem_mask  = mask_q;
    assign bus.o_mem_wen   = wen_q;

    // Output pulses; everything is forced low while reset is applied.
    always_comb begin
        bus.o_imem_ready = 1'b0;
        bus.o_imem_valid = 1'b0;
        bus.o_imem_rdata = 32'h0;
        bus.o_dmem_ready = 1'b0;
        bus.o_dmem_valid = 1'b0;
        bus.o_dmem_rdata = 32'h0;
        bus.o_dmem_err   = 1'b0;
        bus.o_mem_req    = 1'b0;
        o_busy           = 1'b0;
        if (!i_rst) begin
            bus.o_imem_ready = grant_imem;
            bus.o_dmem_ready = grant_dmem;
            o_busy           = (state_q != S_IDLE);
            case (state_q)
                S_ISSUE: bus.o_mem_req = 1'b1;
                S_WAIT: begin
                    if (bus.i_mem_valid) begin
                        if (owner_dmem_q) begin
                            bus.o_dmem_valid = 1'b1;
                            bus.o_dmem_rdata = wen_q ? 32'h0 : bus.i_mem_rdata;
                        end else begin
                            bus.o_imem_valid = 1'b1;
                            bus.o_imem_rdata = bus.i_mem_rdata;
                        end
                    end
                end
                S_ERR: begin
                    bus.o_dmem_valid = 1'b1;
                    bus.o_dmem_err   = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, directed scenarios with
// literal expectations, then randomized traffic with random memory timing and resets.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus    (bus),
        .o_busy (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the one outstanding transaction and how far along it is.
    // stage 0 = nothing outstanding, 1 = waiting for memory accept,
    // 2 = waiting for memory data, 3 = error report due.
    int          m_stage;
    bit          m_owner_dmem, m_wen, m_last_dmem;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;

    bit          e_iready, e_dready, e_ivalid, e_dvalid, e_derr, e_mreq, e_busy;
    logic [31:0] e_irdata, e_drdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Derive expected outputs for the current inputs, then compare every output.
    task automatic settle();
        bit win_d;
        #1;
        {e_iready, e_dready, e_ivalid, e_dvalid, e_derr, e_mreq, e_busy} = '0;
        e_irdata = 32'h0;
        e_drdata = 32'h0;
        if (!rst) begin
            e_busy = (m_stage != 0);
            case (m_stage)
                0: begin
                    if (bus.i_dmem_req && bus.i_imem_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        win_d = !m_last_dmem;
`else
                        win_d = 1'b1;
`endif
                    end else begin
                        win_d = bus.i_dmem_req;
                    end
                    e_dready = win_d;
                    e_iready = bus.i_imem_req && !win_d;
                end
                1: e_mreq = 1'b1;
                2: if (bus.i_mem_valid) begin
                    if (m_owner_dmem) begin
                        e_dvalid = 1'b1;
                        e_drdata = m_wen ? 32'h0 : bus.i_mem_rdata;
                    end else begin
                        e_ivalid = 1'b1;
                        e_irdata = bus.i_mem_rdata;
                    end
                end
                3: begin
                    e_dvalid = 1'b1;
                    e_derr   = 1'b1;
                end
                default: ;
            endcase
        end
        chk("imem_ready", 32'(bus.o_imem_ready), 32'(e_iready));
        chk("imem_valid", 32'(bus.o_imem_valid), 32'(e_ivalid));
        chk("imem_rdata", bus.o_imem_rdata, e_irdata);
        chk("dmem_ready", 32'(bus.o_dmem_ready), 32'(e_dready));
        chk("dmem_valid", 32'(bus.o_dmem_valid), 32'(e_dvalid));
        chk("dmem_rdata", bus.o_dmem_rdata, e_drdata);
        chk("dmem_err", 32'(bus.o_dmem_err), 32'(e_derr));
        chk("mem_req", 32'(bus.o_mem_req), 32'(e_mreq));
        chk("mem_addr", bus.o_mem_addr, m_addr);
        chk("mem_wdata", bus.o_mem_wdata, m_wdata);
        chk("mem_mask", 32'(bus.o_mem_mask), 32'(m_mask));
        chk("mem_wen", 32'(bus.o_mem_wen), 32'(m_wen));
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    // Advance the model across a rising edge, then return to the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_stage = 0;
            m_owner_dmem = 0; m_wen = 0; m_last_dmem = 0;
            m_addr = 0; m_wdata = 0; m_mask = 0;
        end else begin
            case (m_stage)
                0: begin
                    if (e_dready) begin
                        m_owner_dmem = 1; m_last_dmem = 1;
                        m_addr = bus.i_dmem_addr; m_wdata = bus.i_dmem_wdata;
                        m_mask = bus.i_dmem_mask; m_wen = bus.i_dmem_wen;
                        m_stage = (bus.i_dmem_ren && bus.i_dmem_wen) ? 3 : 1;
                    end else if (e_iready) begin
                        m_owner_dmem = 0; m_last_dmem = 0;
                        m_addr = bus.i_imem_addr; m_wdata = 0; m_mask = 4'hF; m_wen = 0;
                        m_stage = 1;
                    end
                end
                1: if (bus.i_mem_ready) m_stage = 2;
                2: if (bus.i_mem_valid) m_stage = 0;
                default: m_stage = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_imem_req = 0; bus.i_imem_addr = 0;
        bus.i_dmem_req = 0; bus.i_dmem_ren = 0; bus.i_dmem_wen = 0;
        bus.i_dmem_addr = 0; bus.i_dmem_wdata = 0; bus.i_dmem_mask = 0;
        bus.i_mem_ready = 0; bus.i_mem_valid = 0; bus.i_mem_rdata = 0;
    endtask

    initial begin
        logic [31:0] r;
        bit          iacc, dacc;
        int          kind;

        m_stage = 0; m_owner_dmem = 0; m_wen = 0; m_last_dmem = 0;
        m_addr = 0; m_wdata = 0; m_mask = 0;
        rst = 1;
        clear_inputs();
        @(negedge clk);
        settle(); tick();
        settle(); tick();
        rst = 0;

        // Reset state
        settle();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_req", 32'(bus.o_mem_req), 32'h0);
        chk("rst_mem_addr", bus.o_mem_addr, 32'h0);
        tick();

        // Single fetch, minimum latency
        bus.i_imem_req = 1; bus.i_imem_addr = 32'h10; bus.i_mem_ready = 1;
        settle(); chk("f_ready_N", 32'(bus.o_imem_ready), 32'h1); tick();
        bus.i_imem_req = 0;
        settle();
        chk("f_mreq_N1", 32'(bus.o_mem_req), 32'h1);
        chk("f_addr_N1", bus.o_mem_addr, 32'h10);
        tick();
        bus.i_mem_ready = 0; bus.i_mem_valid = 1; bus.i_mem_rdata = 32'h00A00093;
        settle();
        chk("f_valid_N2", 32'(bus.o_imem_valid), 32'h1);
        chk("f_rdata_N2", bus.o_imem_rdata, 32'h00A00093);
        tick();
        bus.i_mem_valid = 0;
        settle(); chk("f_idle_N3", 32'(busy), 32'h0); tick();

        // Simultaneous fetch and data read; last grant was the fetch, so dmem wins either way
        bus.i_imem_req = 1; bus.i_imem_addr = 32'h100;
        bus.i_dmem_req = 1; bus.i_dmem_ren = 1; bus.i_dmem_addr = 32'h200; bus.i_dmem_mask = 4'hF;
        settle();
        chk("tie_dready", 32'(bus.o_dmem_ready), 32'h1);
        chk("tie_iready", 32'(bus.o_imem_ready), 32'h0);
        tick();
        bus.i_dmem_req = 0; bus.i_dmem_ren = 0; bus.i_mem_ready = 1;
        settle(); chk("tie_addr", bus.o_mem_addr, 32'h200); tick();
        bus.i_mem_ready = 0; bus.i_mem_valid = 1; bus.i_mem_rdata = 32'h12345678;
        settle(); chk("tie_drdata", bus.o_dmem_rdata, 32'h12345678); tick();
        bus.i_mem_valid = 0;
        settle(); chk("tie_iready2", 32'(bus.o_imem_ready), 32'h1); tick();
        bus.i_imem_req = 0; bus.i_mem_ready = 1;
        settle(); chk("tie_iaddr", bus.o_mem_addr, 32'h100); tick();
        bus.i_mem_ready = 0; bus.i_mem_valid = 1; bus.i_mem_rdata = 32'hCAFE0001;
        settle(); chk("tie_ivalid", 32'(bus.o_imem_valid), 32'h1); tick();
        bus.i_mem_valid = 0;

        // Data write with memory accept delayed three cycles
        bus.i_dmem_req = 1; bus.i_dmem_wen = 1; bus.i_dmem_addr = 32'h300;
        bus.i_dmem_mask = 4'b1100; bus.i_dmem_wdata = 32'hBEEF0000;
        settle(); tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            bus.i_mem_ready = (i == 3);
            settle();
            chk("wr_mreq", 32'(bus.o_mem_req), 32'h1);
            chk("wr_addr", bus.o_mem_addr, 32'h300);
            chk("wr_wdata", bus.o_mem_wdata, 32'hBEEF0000);
            chk("wr_mask", 32'(bus.o_mem_mask), 32'hC);
            chk("wr_wen", 32'(bus.o_mem_wen), 32'h1);
            tick();
        end
        bus.i_mem_ready = 0; bus.i_mem_valid = 1; bus.i_mem_rdata = 32'hFFFFFFFF;
        settle();
        chk("wr_valid", 32'(bus.o_dmem_valid), 32'h1);
        chk("wr_rdata", bus.o_dmem_rdata, 32'h0);
        chk("wr_err", 32'(bus.o_dmem_err), 32'h0);
        tick();
        bus.i_mem_valid = 0;

        // Read+write request is an error with no memory access
        bus.i_dmem_req = 1; bus.i_dmem_ren = 1; bus.i_dmem_wen = 1; bus.i_dmem_addr = 32'h400;
        bus.i_mem_ready = 1;
        settle(); chk("err_ready", 32'(bus.o_dmem_ready), 32'h1); tick();
        bus.i_dmem_req = 0; bus.i_dmem_ren = 0; bus.i_dmem_wen = 0;
        settle();
        chk("err_valid", 32'(bus.o_dmem_valid), 32'h1);
        chk("err_err", 32'(bus.o_dmem_err), 32'h1);
        chk("err_mreq", 32'(bus.o_mem_req), 32'h0);
        tick();
        settle(); chk("err_mreq2", 32'(bus.o_mem_req), 32'h0); tick();
        clear_inputs();

        // Reset while waiting for data, then a stale response
        bus.i_imem_req = 1; bus.i_imem_addr = 32'h40; bus.i_mem_ready = 1;
        settle(); tick();
        bus.i_imem_req = 0;
        settle(); tick();
        bus.i_mem_ready = 0; rst = 1;
        settle(); tick();
        rst = 0; bus.i_mem_valid = 1; bus.i_mem_rdata = 32'h55AA55AA;
        settle();
        chk("rw_ivalid", 32'(bus.o_imem_valid), 32'h0);
        chk("rw_busy", 32'(busy), 32'h0);
        tick();
        bus.i_mem_valid = 0; bus.i_imem_req = 1; bus.i_imem_addr = 32'h44;
        settle(); chk("rw_ready", 32'(bus.o_imem_ready), 32'h1); tick();
        bus.i_imem_req = 0; bus.i_mem_ready = 1;
        settle(); tick();
        bus.i_mem_ready = 0; bus.i_mem_valid = 1; bus.i_mem_rdata = 32'h0BADF00D;
        settle(); chk("rw_rdata", bus.o_imem_rdata, 32'h0BADF00D); tick();
        clear_inputs();

        // Randomized traffic
        iacc = 0; dacc = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (iacc) bus.i_imem_req = 0;
            if (dacc) bus.i_dmem_req = 0;
            if (!bus.i_imem_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    r = $urandom;
                    bus.i_imem_req = 1; bus.i_imem_addr = {r[31:2], 2'b00};
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.i_imem_req = 0;
            end
            if (!bus.i_dmem_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    r = $urandom;
                    kind = $urandom_range(0, 9);
                    bus.i_dmem_req = 1; bus.i_dmem_addr = {r[31:2], 2'b00};
                    bus.i_dmem_wdata = $urandom; bus.i_dmem_mask = 4'($urandom);
                    bus.i_dmem_ren = (kind < 5) || (kind == 9);
                    bus.i_dmem_wen = (kind >= 5);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.i_dmem_req = 0;
            end
            bus.i_mem_ready = 1'($urandom_range(0, 1));
            bus.i_mem_valid = ($urandom_range(0, 2) == 0);
            bus.i_mem_rdata = $urandom;
            settle();
            iacc = e_iready;
            dacc = e_dready;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
